// File: rtl/mtimer_uh.sv
// Machine timer (MTIME/MTIMECMP) with prescaler, exposed as a TileLink-UH slave.
// Bursts walk the eight-word register map with wraparound on the word index.
module mtimer_uh #(
  parameter int unsigned SOURCE_WIDTH   = 1,
  parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
  input  logic                    tilelink_clock_i,
  input  logic                    tilelink_reset_i,

  input  logic [2:0]              tl_a_opcode,
  input  logic [2:0]              tl_a_param,
  input  logic [2:0]              tl_a_size,
  input  logic [SOURCE_WIDTH-1:0] tl_a_source,
  input  logic [4:0]              tl_a_address,
  input  logic [3:0]              tl_a_mask,
  input  logic [31:0]             tl_a_data,
  input  logic                    tl_a_corrupt,
  input  logic                    tl_a_valid,
  output logic                    tl_a_ready,

  output logic [2:0]              tl_d_opcode,
  output logic [1:0]              tl_d_param,
  output logic [2:0]              tl_d_size,
  output logic [SOURCE_WIDTH-1:0] tl_d_source,
  output logic                    tl_d_denied,
  output logic [31:0]             tl_d_data,
  output logic                    tl_d_corrupt,
  output logic                    tl_d_valid,
  input  logic                    tl_d_ready,

  output logic                    mtip_o
);

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpLogical    = 3'd3;
  localparam logic [2:0] OpGet        = 3'd4;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StWack} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             mtime_q, mtime_d;
  logic [63:0]             mtimecmp_q, mtimecmp_d;
  logic                    enable_q, enable_d;
  logic [31:0]             prescale_q, prescale_d;
  logic [31:0]             pcnt_q, pcnt_d;
  logic                    mtip_q, mtip_d;
  logic [SOURCE_WIDTH-1:0] src_q, src_d;
  logic [2:0]              size_q, size_d;
  logic [2:0]              idx_q, idx_d;
  logic [4:0]              beat_q, beat_d;
  logic [2:0]              op_q, op_d;
  logic                    denied_q, denied_d;
  logic                    first_q, first_d;
  logic [31:0]             rdata_q, rdata_d;

  logic        tick;
  logic        a_fire, d_fire;
  logic        in_put, in_get, in_data, in_size_ok;
  logic        we;
  logic [2:0]  widx, ridx;
  logic [31:0] wdata, live;
  logic [3:0]  wmask;
  logic [31:0] reg_rd [8];

  logic unused_ok;
  assign unused_ok = ^{tl_a_param, tl_a_address[1:0]};

  // Index of the final beat: 0 for single-beat sizes, 2^(size-2)-1 otherwise.
  function automatic logic [4:0] last_beat(input logic [2:0] size);
    logic [5:0] n;
    if (size <= 3'd2) n = 6'd1;
    else              n = 6'd1 << (size - 3'd2);
    return 5'(n - 6'd1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) reg_rd[i] = 32'd0;
    reg_rd[0] = mtime_q[31:0];
    reg_rd[1] = mtime_q[63:32];
    reg_rd[2] = mtimecmp_q[31:0];
    reg_rd[3] = mtimecmp_q[63:32];
    reg_rd[4] = {31'd0, enable_q};
    reg_rd[5] = prescale_q;
  end

  assign tl_a_ready   = (state_q == StIdle) || (state_q == StWrite);
  assign tl_d_valid   = (state_q == StRead) || (state_q == StWack);
  assign tl_d_opcode  = (state_q == StRead) ? 3'd1 : 3'd0;
  assign tl_d_param   = 2'd0;
  assign tl_d_corrupt = 1'b0;
  assign tl_d_size    = size_q;
  assign tl_d_source  = src_q;
  assign tl_d_denied  = denied_q;
  assign mtip_o       = mtip_q;

  assign a_fire     = tl_a_valid && tl_a_ready;
  assign d_fire     = tl_d_valid && tl_d_ready;
  assign in_put     = (tl_a_opcode == OpPutFull) || (tl_a_opcode == OpPutPartial);
  assign in_get     = (tl_a_opcode == OpGet);
  assign in_data    = (tl_a_opcode <= OpLogical);
  assign in_size_ok = (tl_a_size <= 3'd4);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    size_d     = size_q;
    idx_d      = idx_q;
    beat_d     = beat_q;
    op_d       = op_q;
    denied_d   = denied_q;
    first_d    = first_q;
    rdata_d    = rdata_q;
    mtimecmp_d = mtimecmp_q;
    enable_d   = enable_q;
    prescale_d = prescale_q;
    we         = 1'b0;
    widx       = 3'd0;
    wdata      = tl_a_data;
    wmask      = tl_a_mask;
    ridx       = idx_q + beat_q[2:0];
    live       = denied_q ? 32'd0 : reg_rd[ridx];
    tl_d_data  = 32'd0;

    tick   = enable_q && (pcnt_q == prescale_q);
    pcnt_d = enable_q ? (tick ? 32'd0 : pcnt_q + 32'd1) : pcnt_q;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    mtip_d  = enable_q && (mtime_q >= mtimecmp_q);

    unique case (state_q)
      StIdle: begin
        if (a_fire) begin
          src_d    = tl_a_source;
          size_d   = tl_a_size;
          idx_d    = tl_a_address[4:2];
          op_d     = tl_a_opcode;
          beat_d   = 5'd0;
          first_d  = 1'b1;
          denied_d = !((in_put || in_get) && in_size_ok) || (in_put && tl_a_corrupt);
          we       = in_put && in_size_ok && !tl_a_corrupt;
          widx     = tl_a_address[4:2];
          if (!in_data) begin
            state_d = StRead;
          end else if (last_beat(tl_a_size) == 5'd0) begin
            state_d = in_put ? StWack : StRead;
          end else begin
            state_d = StWrite;
            beat_d  = 5'd1;
          end
        end
      end
      StWrite: begin
        if (a_fire) begin
          widx = idx_q + beat_q[2:0];
          we   = (op_q <= OpPutPartial) && (size_q <= 3'd4) && !tl_a_corrupt;
          if ((op_q <= OpPutPartial) && tl_a_corrupt) denied_d = 1'b1;
          if (beat_q == last_beat(size_q)) begin
            state_d = (op_q <= OpPutPartial) ? StWack : StRead;
            beat_d  = 5'd0;
            first_d = 1'b1;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      StRead: begin
        // First cycle of a beat shows the live register, later cycles the captured copy.
        tl_d_data = first_q ? live : rdata_q;
        if (first_q) begin
          rdata_d = live;
          first_d = 1'b0;
        end
        if (d_fire) begin
          if (beat_q == last_beat(size_q)) begin
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 5'd1;
            first_d = 1'b1;
          end
        end
      end
      StWack: begin
        if (d_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Byte merges land on top of the tick-incremented MTIME.
    if (we) begin
      case (widx)
        3'd0: mtime_d[31:0]     = merge(mtime_d[31:0], wdata, wmask);
        3'd1: mtime_d[63:32]    = merge(mtime_d[63:32], wdata, wmask);
        3'd2: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata, wmask);
        3'd3: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, wmask);
        3'd4: begin
          if (wmask[0]) enable_d = wdata[0];
          pcnt_d = 32'd0;
        end
        3'd5: begin
          prescale_d = merge(prescale_q, wdata, wmask);
          pcnt_d     = 32'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      state_q    <= StIdle;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_q   <= 1'b0;
      prescale_q <= PRESCALE_RESET;
      pcnt_q     <= 32'd0;
      mtip_q     <= 1'b0;
      src_q      <= '0;
      size_q     <= 3'd0;
      idx_q      <= 3'd0;
      beat_q     <= 5'd0;
      op_q       <= 3'd0;
      denied_q   <= 1'b0;
      first_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      enable_q   <= enable_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      mtip_q     <= mtip_d;
      src_q      <= src_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      op_q       <= op_d;
      denied_q   <= denied_d;
      first_q    <= first_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mtimer_uh.sv
// Directed bench for mtimer_uh: register access, prescaler, interrupt, bursts, reset.
module tb_mtimer_uh;

  logic        clk;
  logic        rst;
  logic [2:0]  tl_a_opcode, tl_a_param, tl_a_size;
  logic [0:0]  tl_a_source;
  logic [4:0]  tl_a_address;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_data;
  logic        tl_a_corrupt, tl_a_valid, tl_a_ready;
  logic [2:0]  tl_d_opcode, tl_d_size;
  logic [1:0]  tl_d_param;
  logic [0:0]  tl_d_source;
  logic        tl_d_denied, tl_d_corrupt, tl_d_valid, tl_d_ready;
  logic [31:0] tl_d_data;
  logic        mtip;

  int checks = 0;
  int errors = 0;

  mtimer_uh dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .tl_a_opcode      (tl_a_opcode),
    .tl_a_param       (tl_a_param),
    .tl_a_size        (tl_a_size),
    .tl_a_source      (tl_a_source),
    .tl_a_address     (tl_a_address),
    .tl_a_mask        (tl_a_mask),
    .tl_a_data        (tl_a_data),
    .tl_a_corrupt     (tl_a_corrupt),
    .tl_a_valid       (tl_a_valid),
    .tl_a_ready       (tl_a_ready),
    .tl_d_opcode      (tl_d_opcode),
    .tl_d_param       (tl_d_param),
    .tl_d_size        (tl_d_size),
    .tl_d_source      (tl_d_source),
    .tl_d_denied      (tl_d_denied),
    .tl_d_data        (tl_d_data),
    .tl_d_corrupt     (tl_d_corrupt),
    .tl_d_valid       (tl_d_valid),
    .tl_d_ready       (tl_d_ready),
    .mtip_o           (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (obs >= 32'(lo) && obs <= 32'(hi)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the A beat fires.
  task automatic a_fire(input logic [2:0] op, input logic [2:0] size, input logic [4:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input logic corrupt);
    int n;
    tl_a_opcode  = op;
    tl_a_size    = size;
    tl_a_address = addr;
    tl_a_data    = data;
    tl_a_mask    = mask;
    tl_a_corrupt = corrupt;
    tl_a_valid   = 1'b1;
    n = 0;
    while (!tl_a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tl_a_ready) begin
      checks++;
      errors++;
      $error("FAIL a_ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    tl_a_valid   = 1'b0;
    tl_a_corrupt = 1'b0;
  endtask

  task automatic d_take(output logic [31:0] data, output logic [2:0] opc, output logic den);
    int n;
    n = 0;
    while (!tl_d_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tl_d_valid) begin
      checks++;
      errors++;
      $error("FAIL d_valid_timeout observed=0 expected=1");
      data = 'x;
      opc  = 'x;
      den  = 'x;
    end else begin
      data = tl_d_data;
      opc  = tl_d_opcode;
      den  = tl_d_denied;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic put_w(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, output logic [2:0] opc, output logic den);
    logic [31:0] dummy;
    a_fire(op, 3'd2, addr, data, mask, 1'b0);
    d_take(dummy, opc, den);
  endtask

  task automatic get_w(input logic [4:0] addr, output logic [31:0] data);
    logic [2:0] opc;
    logic       den;
    a_fire(3'd4, 3'd2, addr, 32'd0, 4'hF, 1'b0);
    d_take(data, opc, den);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  opc;
    logic        den;
    logic [31:0] exp_b [4];

    rst = 1'b1;
    tl_a_opcode = 3'd0; tl_a_param = 3'd0; tl_a_size = 3'd2; tl_a_source = 1'b1;
    tl_a_address = 5'd0; tl_a_mask = 4'hF; tl_a_data = 32'd0; tl_a_corrupt = 1'b0;
    tl_a_valid = 1'b0; tl_d_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_a_ready", 64'(tl_a_ready), 64'd1);
    check("rst_d_valid", 64'(tl_d_valid), 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    get_w(5'h08, rd); check("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    get_w(5'h10, rd); check("rst_ctrl", 64'(rd), 64'd0);

    // Interrupt timing with PRESCALE=0, MTIMECMP=5
    put_w(3'd0, 5'h0C, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h08, 32'd5, 4'hF, opc, den);
    check("put_ack_opcode", 64'(opc), 64'd0);
    check("put_ack_denied", 64'(den), 64'd0);
    a_fire(3'd0, 3'd2, 5'h10, 32'd1, 4'hF, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("mtip_before", 64'(mtip), 64'd0);
      if (i == 6) check("mtip_rise", 64'(mtip), 64'd1);
    end
    a_fire(3'd0, 3'd2, 5'h0C, 32'd1, 4'hF, 1'b0);
    check("mtip_hold", 64'(mtip), 64'd1);
    @(negedge clk);
    check("mtip_fall", 64'(mtip), 64'd0);

    // Partial write, corrupt write, unsupported opcode
    put_w(3'd0, 5'h10, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h00, 32'hFFFF_FFFF, 4'hF, opc, den);
    put_w(3'd1, 5'h00, 32'h0000_AB00, 4'b0010, opc, den);
    get_w(5'h00, rd); check("partial_write", 64'(rd), 64'hFFFF_ABFF);
    a_fire(3'd0, 3'd2, 5'h08, 32'h1234, 4'hF, 1'b1);
    d_take(rd, opc, den);
    check("corrupt_denied", 64'(den), 64'd1);
    get_w(5'h08, rd); check("corrupt_nowrite", 64'(rd), 64'd5);
    a_fire(3'd2, 3'd2, 5'h14, 32'd7, 4'hF, 1'b0);
    d_take(rd, opc, den);
    check("arith_opcode", 64'(opc), 64'd1);
    check("arith_denied", 64'(den), 64'd1);
    get_w(5'h14, rd); check("arith_nochange", 64'(rd), 64'd0);
    get_w(5'h18, rd); check("word6_zero", 64'(rd), 64'd0);

    // Carry from LO into HI
    put_w(3'd0, 5'h00, 32'hFFFF_FFFF, 4'hF, opc, den);
    put_w(3'd0, 5'h04, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h10, 32'd1, 4'hF, opc, den);
    get_w(5'h04, rd); check("carry_hi", 64'(rd), 64'd1);
    get_w(5'h00, rd); check_range("carry_lo", rd, 2, 4);

    // 64-bit wrap
    put_w(3'd0, 5'h10, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h04, 32'hFFFF_FFFF, 4'hF, opc, den);
    put_w(3'd0, 5'h00, 32'hFFFF_FFFF, 4'hF, opc, den);
    put_w(3'd0, 5'h10, 32'd1, 4'hF, opc, den);
    get_w(5'h04, rd); check("wrap_hi", 64'(rd), 64'd0);

    // Prescaler divide-by-4
    put_w(3'd0, 5'h10, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h00, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h04, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h14, 32'd3, 4'hF, opc, den);
    put_w(3'd0, 5'h10, 32'd1, 4'hF, opc, den);
    repeat (38) @(negedge clk);
    get_w(5'h00, rd); check_range("prescale_40", rd, 9, 11);

    // 4-beat Get with back-pressure
    put_w(3'd0, 5'h10, 32'd0, 4'hF, opc, den);
    put_w(3'd0, 5'h00, 32'h3333_4444, 4'hF, opc, den);
    put_w(3'd0, 5'h04, 32'h1111_2222, 4'hF, opc, den);
    put_w(3'd0, 5'h08, 32'h5555_6666, 4'hF, opc, den);
    put_w(3'd0, 5'h0C, 32'h7777_8888, 4'hF, opc, den);
    exp_b[0] = 32'h3333_4444; exp_b[1] = 32'h1111_2222;
    exp_b[2] = 32'h5555_6666; exp_b[3] = 32'h7777_8888;
    a_fire(3'd4, 3'd4, 5'h00, 32'd0, 4'hF, 1'b0);
    check("burst_opcode", 64'(tl_d_opcode), 64'd1);
    check("burst_size", 64'(tl_d_size), 64'd4);
    for (int k = 0; k < 4; k++) begin
      tl_d_ready = 1'b0;
      check("burst_valid", 64'(tl_d_valid), 64'd1);
      check("burst_data", 64'(tl_d_data), 64'(exp_b[k]));
      @(negedge clk);
      check("burst_hold", 64'(tl_d_data), 64'(exp_b[k]));
      tl_d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("burst_done", 64'(tl_d_valid), 64'd0);

    // Reset during beat 2 of a 4-beat Get
    a_fire(3'd4, 3'd4, 5'h00, 32'd0, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rstb_beat2", 64'(tl_d_data), 64'(exp_b[2]));
    rst = 1'b1;
    tl_d_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstb_d_valid", 64'(tl_d_valid), 64'd0);
    check("rstb_a_ready", 64'(tl_a_ready), 64'd1);
    rst = 1'b0;
    tl_d_ready = 1'b1;
    get_w(5'h00, rd); check("rstb_mtime_lo", 64'(rd), 64'd0);
    get_w(5'h04, rd); check("rstb_mtime_hi", 64'(rd), 64'd0);
    get_w(5'h08, rd); check("rstb_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    get_w(5'h0C, rd); check("rstb_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    get_w(5'h10, rd); check("rstb_ctrl", 64'(rd), 64'd0);
    get_w(5'h14, rd); check("rstb_prescale", 64'(rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
